// File: rtl/mem_access_pkg.sv
// Shared op-field constants, response codes, FSM encoding and request classification
// for the MEM-stage DataMemory initiator.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int OP_STORE_BIT = 3;
    localparam int OP_UNS_BIT   = 2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        LD_DONE = 3'd2,
        WR      = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        ERR     = 3'd6
    } state_t;

    // Priority: illegal size, then misalignment, then address beyond the memory.
    function automatic logic [1:0] classify_req(input logic [1:0] size,
                                                input logic [31:0] addr,
                                                input int unsigned mem_aw);
        if (size == SZ_ILL)
            return ERR_SIZE;
        if ((size == SZ_WORD && addr[1:0] != 2'b00) || (size == SZ_HALF && addr[0]))
            return ERR_MISALIGN;
        if ((addr >> (mem_aw + 2)) != 32'd0)
            return ERR_RANGE;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends sub-word loads, and merges
// sub-word store data into the word read back from memory.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_rdata[{i_lane, 3'b000} +: 8];
        w_half  = i_rdata[{i_lane[1], 4'b0000} +: 16];
        o_load  = i_rdata;
        o_merge = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load  = {{24{w_byte[7] & ~i_uns}}, w_byte};
                o_merge = i_rdata;
                o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load  = {{16{w_half[15] & ~i_uns}}, w_half};
                o_merge = i_rdata;
                o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for the word-addressed DataMemory; sub-word
// stores are done as read-modify-write. Handshake: a request is taken on the edge
// where req_valid & req_ready, req_ready is 1 only in IDLE, and the request is
// held stable by the pipeline until taken.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_AW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [1:0]        resp_err,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    output state_t            o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  w_req_err;
    logic [1:0]  w_lat_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_req_err = classify_req(req_op[1:0], req_addr, MEM_AW);
    assign w_lat_err = classify_req(r_op[1:0], r_addr, MEM_AW);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err != ERR_OK)
                        w_next = ERR;
                    else if (!req_op[OP_STORE_BIT])
                        w_next = RD;
                    else if (req_op[1:0] == SZ_WORD)
                        w_next = WR;
                    else
                        w_next = RMW_RD;
                end
            end
            RD:      w_next = LD_DONE;
            RMW_RD:  w_next = RMW_WR;
            LD_DONE,
            WR,
            RMW_WR,
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    mem_lane_align u_align (
        .i_size  (r_op[1:0]),
        .i_uns   (r_op[OP_UNS_BIT]),
        .i_lane  (r_addr[1:0]),
        .i_rdata (mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load_data),
        .o_merge (w_merge_data)
    );

    // Everything below is a pure decode of state and the latched request.
    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign mem_read    = (r_state == RD) || (r_state == RMW_RD);
    assign mem_write   = (r_state == WR) || (r_state == RMW_WR);
    assign mem_addr    = r_addr[MEM_AW+1:2];
    assign mem_wdata   = (r_state == RMW_WR) ? w_merge_data : r_wdata;
    assign resp_valid  = (r_state == LD_DONE) || (r_state == WR) ||
                         (r_state == RMW_WR) || (r_state == ERR);
    assign resp_err    = (r_state == ERR) ? w_lat_err : ERR_OK;
    assign resp_rdata  = (r_state == LD_DONE && !r_op[OP_STORE_BIT]) ? w_load_data : 32'd0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural DataMemory, directed cases
// and randomized requests checked against an arithmetic reference model.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int MEM_AW = 11;
    localparam int NWORDS = 2048;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [1:0]        resp_err;
    logic [31:0]       resp_rdata;
    logic              busy;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;
    state_t            dbg_state;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 5)
            return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // DataMemory: read data registered one edge after mem_read
    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = init_word(i);
        mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (mem_read) mem_rdata <= mem[mem_addr];
            if (mem_write) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_eq("rw_excl", 32'(mem_read & mem_write), 32'd0);
        if (!resp_valid)
            check_eq("resp_quiet", {resp_rdata[31:2], resp_rdata[1:0] | resp_err}, 32'd0);
    end

    // Reference: result of one request from byte-size arithmetic on ref_mem.
    function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [1:0] err,
                                  output logic [31:0] rdata, output logic [31:0] wword,
                                  output int lat, output int nrd, output int nwr);
        int nbytes;
        int sh;
        logic [31:0] mask, word, v;
        nbytes = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        err = 2'd0; rdata = '0; wword = '0; lat = 1; nrd = 0; nwr = 0;
        if (op[1:0] == 2'd3) begin err = 2'd3; return; end
        if ((addr % 32'(nbytes)) != 32'd0) begin err = 2'd1; return; end
        if (addr >= 32'd8192) begin err = 2'd2; return; end
        word = ref_mem[addr[12:2]];
        sh   = 8 * int'(addr[1:0]);
        mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (!op[3]) begin
            v = (word >> sh) & mask;
            if (!op[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            rdata = v; lat = 2; nrd = 1;
        end else begin
            wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            nwr = 1;
            if (nbytes < 4) begin lat = 2; nrd = 1; end
        end
    endfunction

    // driver: call at a negedge; returns at the negedge of the response cycle
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold,
                           output logic [1:0] o_err, output logic [31:0] o_rdata,
                           output int waits);
        logic [1:0]  e_err;
        logic [31:0] e_rdata, e_wword;
        int e_lat, e_nrd, e_nwr, nrd, nwr, cyc;
        bit done;
        model(op, addr, wdata, e_err, e_rdata, e_wword, e_lat, e_nrd, e_nwr);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        o_err = '0; o_rdata = '0; waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        nrd = 0; nwr = 0; cyc = 1; done = 0;
        while (!done && cyc <= 8) begin
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("req_ready_low", 32'(req_ready), 32'd0);
            if (cyc == 1) check_eq("rd_cycle1", 32'(mem_read), 32'(e_nrd));
            if (mem_read) begin
                nrd++;
                check_eq("rd_addr", 32'(mem_addr), 32'(addr[12:2]));
            end
            if (mem_write) begin
                nwr++;
                check_eq("wr_addr", 32'(mem_addr), 32'(addr[12:2]));
                check_eq("wr_data", mem_wdata, e_wword);
            end
            if (resp_valid) begin
                done = 1;
                check_eq("latency", 32'(cyc), 32'(e_lat));
                check_eq("resp_err", 32'(resp_err), 32'(e_err));
                check_eq("resp_rdata", resp_rdata, e_rdata);
                o_err = resp_err; o_rdata = resp_rdata;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
        check_eq("n_read", 32'(nrd), 32'(e_nrd));
        check_eq("n_write", 32'(nwr), 32'(e_nwr));
        if (e_err == 2'd0 && op[3]) ref_mem[addr[12:2]] = e_wword;
    endtask

    localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100, OP_LHU = 4'b0101, OP_BAD = 4'b0011;
    localparam logic [3:0] OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

    initial begin
        logic [1:0]  err;
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [3:0]  op;
        logic [31:0] addr;
        int          w;

        for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
        check_eq("rst_dbg_state", 32'(dbg_state), 32'(IDLE));

        // loads
        run_req(OP_LW, 32'h14, 32'h0, 1'b0, err, rd, w);
        check_eq("lw", rd, 32'h8899AABB);
        run_req(OP_LB, 32'h15, 32'h0, 1'b0, err, rd, w);
        check_eq("lb", rd, 32'hFFFFFFAA);
        run_req(OP_LBU, 32'h15, 32'h0, 1'b0, err, rd, w);
        check_eq("lbu", rd, 32'h000000AA);
        run_req(OP_LH, 32'h16, 32'h0, 1'b0, err, rd, w);
        check_eq("lh", rd, 32'hFFFF8899);
        run_req(OP_LHU, 32'h16, 32'h0, 1'b0, err, rd, w);
        check_eq("lhu", rd, 32'h00008899);

        // sub-word stores by read-modify-write
        run_req(OP_SB, 32'h16, 32'h12345677, 1'b0, err, rd, w);
        run_req(OP_LW, 32'h14, 32'h0, 1'b0, err, rd, w);
        check_eq("sb_readback", rd, 32'h8877AABB);
        run_req(OP_SH, 32'h14, 32'h0000BEEF, 1'b0, err, rd, w);
        run_req(OP_LW, 32'h14, 32'h0, 1'b0, err, rd, w);
        check_eq("sh_readback", rd, 32'h8877BEEF);

        // errors
        run_req(OP_LW, 32'h13, 32'h0, 1'b0, err, rd, w);
        check_eq("err_misalign", 32'(err), 32'd1);
        run_req(OP_SW, 32'h2000, 32'hDEADBEEF, 1'b0, err, rd, w);
        check_eq("err_range", 32'(err), 32'd2);
        run_req(OP_BAD, 32'h14, 32'h0, 1'b0, err, rd, w);
        check_eq("err_size", 32'(err), 32'd3);

        // back-to-back with req_valid held high
        run_req(OP_SW, 32'h40, 32'hCAFEF00D, 1'b1, err, rd, w);
        run_req(OP_LW, 32'h40, 32'h0, 1'b1, err, rd, w);
        req_valid = 1'b0;
        check_eq("b2b_wait", 32'(w), 32'd1);
        check_eq("b2b_data", rd, 32'hCAFEF00D);

        // reset during RMW_RD of a byte store
        @(negedge clk);
        req_op = OP_SB; req_addr = 32'h15; req_wdata = 32'h000000FF; req_valid = 1'b1;
        @(negedge clk);
        check_eq("rmw_rd_read", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rw", 32'({mem_read, mem_write}), 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_no_resp_post", 32'(resp_valid), 32'd0);
        run_req(OP_LW, 32'h14, 32'h0, 1'b0, err, rd, w);
        check_eq("abort_word_kept", rd, 32'h8877BEEF);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz};
            if ($urandom_range(0, 7) == 0) begin
                addr = $urandom | 32'h2000;
            end else begin
                addr = 32'($urandom_range(0, 8191));
                if ($urandom_range(0, 3) != 0)
                    addr = addr & ((sz == 2'd2) ? 32'hFFFFFFFC :
                                   (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
            end
            run_req(op, addr, $urandom, 1'b0, err, rd, w);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
